multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath. Takes the decoded instruction id (`INST_*` codes from defines.v) and the ALU `zero` flag.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, so the datapath shares one memory port per phase.
- Handshakes with instruction and data memory through req/ready pairs, with a stall-timeout watchdog.
- Datapath select encodings are the `ALU_SEL_*`, `GPR_WRITE_*`, `ALU_SRC_*`, `EXT_SEL_*` and `IFU_SEL_*` macros from defines.v.

Parameters:
- INST_W, 6, width of dec_inst.
- TIMEOUT_CYCLES, 255, maximum wait cycles for a memory ready; 0 disables the watchdog.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- dec_inst  in  INST_W  decoded instruction id; valid from DECODE onward
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction word available
- dmem_ready  in  1  data access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- ir_write_en  out  1  latch instruction register
- pc_write_en  out  1  update PC from NPC
- reg_write_en  out  1  GPR write strobe
- reg_of_en  out  1  overflow-trap enable for the write
- mem_write_en  out  1  data memory write
- alu_sel  out  2  ALU op
- gpr_write_addr_sel  out  2  GPR destination select
- gpr_write_data_sel  out  2  GPR data select
- alu_src_ctl  out  1  ALU B source
- ext_ctl  out  2  immediate extender mode
- npc_sel  out  2  next-PC source
- halt_sig  out  1  sticky halt
- bus_err  out  1  sticky memory timeout
- state  out  3  current FSM state, for debug

Behaviour:
- States: S_RST=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5, S_HALT=6.
- While rst_n=0: state=S_RST; every output 0; wait counter 0; halt_sig=0; bus_err=0.
- First edge after reset release: S_RST→S_FETCH.
- Enables (imem_req, dmem_req, ir_write_en, pc_write_en, reg_write_en, reg_of_en, mem_write_en) are decoded from state. They are 0 in every state not listed below.
- Select outputs are decoded combinationally from dec_inst in S_DECODE/S_EXEC/S_MEM/S_WB. Defaults: ALU_SEL_ADD, GPR_WRITE_ADDR_RT, GPR_WRITE_ALU, ALU_SRC_EXT, EXT_SEL_SIGN, IFU_SEL_NORM.
- Per-instruction select overrides:
  - ADDU: RD, GPR source.
  - SUBU: SUB, RD, GPR source.
  - SLT: SLT, RD, GPR source.
  - ORI: OR, EXT_SEL_ZERO.
  - LUI: EXT_SEL_LUI.
  - LW: GPR_WRITE_MEM.
  - BEQ: SUB, GPR source.
  - JAL: GPR_RA, GPR_WRITE_PC.
- In S_RST/S_FETCH/S_HALT all selects hold their defaults.
- S_FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_write_en=1 for that cycle; next state S_DECODE.
  - Otherwise stay in S_FETCH and increment the wait counter.
- S_DECODE: one cycle, then branch on dec_inst.
  - HLT → S_HALT.
  - Unknown code → pc_write_en=1, npc_sel=NORM; instruction is skipped with no GPR or memory write; → S_FETCH.
  - All other codes → S_EXEC.
- S_EXEC:
  - BEQ: pc_write_en=1; npc_sel=RELATIVE if zero, else NORM; → S_FETCH. Total 3 cycles.
  - J: pc_write_en=1, npc_sel=IRRELATIVE; → S_FETCH.
  - JR: pc_write_en=1, npc_sel=REGISTER; → S_FETCH.
  - LW, SW → S_MEM.
  - All others → S_WB.
- S_MEM:
  - dmem_req=1; mem_write_en=1 for SW, held until ready.
  - On dmem_ready: LW → S_WB; SW → pc_write_en=1, npc_sel=NORM, → S_FETCH.
  - Otherwise stall and increment the wait counter.
- S_WB: one cycle.
  - reg_write_en=1.
  - reg_of_en=1 only for ADDI.
  - pc_write_en=1; npc_sel=IRRELATIVE for JAL, else NORM.
  - → S_FETCH.
- Latencies with ready asserted immediately (cycles):
  - ALU/imm ops: 4.
  - LW: 5.
  - SW: 4.
  - J/JR/BEQ: 3.
  - JAL: 4.
- Wait counter:
  - Clears on every state change and whenever the awaited ready is seen.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with no ready: bus_err←1, → S_HALT.
  - imem_req/dmem_req drop in S_HALT.
- ready asserted in the same cycle the counter hits the limit: the ready wins; no error.
- S_HALT is absorbing: halt_sig=1, all enables 0; exited only by reset.
- Reset asserted mid-instruction: immediate return to S_RST; no partial write strobes after the asynchronous assertion.
- ready inputs are ignored outside their wait states.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and inst_retired[31:0], both reset to 0.
  - cycle_cnt increments every clock outside S_RST/S_HALT.
  - inst_retired increments on each cycle with pc_write_en=1, excluding unknown-instruction skips.
  - Both counters wrap 0xFFFFFFFF→0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release with imem_ready=1, dec_inst=ADDU → S_RST,FETCH,DECODE,EXEC,WB; reg_write_en=1 only in WB with gpr_write_addr_sel=RD; pc_write_en=1 in WB; back in FETCH at cycle 5.
- BEQ with zero=1, then BEQ with zero=0 → npc_sel=RELATIVE then NORM in EXEC; reg_write_en never 1; 3 cycles each.
- LW with dmem_ready held low 3 cycles → S_MEM lasts 4 cycles with dmem_req=1; reg_write_en pulse with gpr_write_data_sel=MEM; SW case: mem_write_en=1 through the stall, no reg_write_en.
- TIMEOUT_CYCLES=4, imem_ready=0 forever → bus_err=1 after 4 wait cycles, state=S_HALT, imem_req=0; rst_n low clears bus_err.
- HLT decoded → halt_sig=1 persists 20 cycles with no enables; rst_n pulse mid-S_MEM of SW → mem_write_en drops immediately, state=S_RST.
- With PERF_CNT_EN: 10 ADDU instructions, no stalls → inst_retired=10, cycle_cnt=40.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FSM sequencer for the MIPS datapath
// Optional macro PERF_CNT_EN adds cycle_cnt and inst_retired counters.
module multicycle_controller #(
  parameter int INST_W         = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] dec_inst,
  input  logic              zero,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              ir_write_en,
  output logic              pc_write_en,
  output logic              reg_write_en,
  output logic              reg_of_en,
  output logic              mem_write_en,
  output logic [1:0]        alu_sel,
  output logic [1:0]        gpr_write_addr_sel,
  output logic [1:0]        gpr_write_data_sel,
  output logic              alu_src_ctl,
  output logic [1:0]        ext_ctl,
  output logic [1:0]        npc_sel,
  output logic              halt_sig,
  output logic              bus_err,
  output logic [2:0]        state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       inst_retired
`endif
);

  localparam logic [INST_W-1:0] INST_ADDU = INST_W'(1);
  localparam logic [INST_W-1:0] INST_SUBU = INST_W'(2);
  localparam logic [INST_W-1:0] INST_SLT  = INST_W'(3);
  localparam logic [INST_W-1:0] INST_ORI  = INST_W'(4);
  localparam logic [INST_W-1:0] INST_LUI  = INST_W'(5);
  localparam logic [INST_W-1:0] INST_LW   = INST_W'(6);
  localparam logic [INST_W-1:0] INST_SW   = INST_W'(7);
  localparam logic [INST_W-1:0] INST_BEQ  = INST_W'(8);
  localparam logic [INST_W-1:0] INST_J    = INST_W'(9);
  localparam logic [INST_W-1:0] INST_JAL  = INST_W'(10);
  localparam logic [INST_W-1:0] INST_JR   = INST_W'(11);
  localparam logic [INST_W-1:0] INST_ADDI = INST_W'(12);
  localparam logic [INST_W-1:0] INST_HLT  = INST_W'(13);

  localparam logic [1:0] ALU_SEL_ADD = 2'd0, ALU_SEL_SUB = 2'd1, ALU_SEL_OR = 2'd2, ALU_SEL_SLT = 2'd3;
  localparam logic [1:0] GPR_WRITE_ADDR_RT = 2'd0, GPR_WRITE_ADDR_RD = 2'd1, GPR_WRITE_ADDR_RA = 2'd2;
  localparam logic [1:0] GPR_WRITE_ALU = 2'd0, GPR_WRITE_MEM = 2'd1, GPR_WRITE_PC = 2'd2;
  localparam logic       ALU_SRC_EXT = 1'b0, ALU_SRC_GPR = 1'b1;
  localparam logic [1:0] EXT_SEL_SIGN = 2'd0, EXT_SEL_ZERO = 2'd1, EXT_SEL_LUI = 2'd2;
  localparam logic [1:0] IFU_SEL_NORM = 2'd0, IFU_SEL_RELATIVE = 2'd1,
                         IFU_SEL_IRRELATIVE = 2'd2, IFU_SEL_REGISTER = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_t;

  state_t           cur;
  logic [CNT_W-1:0] wait_cnt;
  logic             known;
  logic             timeout_hit;

  assign state = cur;
  assign known = dec_inst inside {INST_ADDU, INST_SUBU, INST_SLT, INST_ORI, INST_LUI,
                                  INST_LW, INST_SW, INST_BEQ, INST_J, INST_JAL,
                                  INST_JR, INST_ADDI, INST_HLT};
  // The watchdog fires on the wait cycle that would bring the count to the limit; ready wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_RST;
      wait_cnt <= '0;
      halt_sig <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      case (cur)
        S_RST: begin
          cur      <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          if (imem_ready) begin
            cur      <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            cur      <= S_HALT;
            bus_err  <= 1'b1;
            halt_sig <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (dec_inst == INST_HLT) begin
            cur      <= S_HALT;
            halt_sig <= 1'b1;
          end else if (!known) begin
            cur <= S_FETCH;
          end else begin
            cur <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (dec_inst inside {INST_BEQ, INST_J, INST_JR}) cur <= S_FETCH;
          else if (dec_inst inside {INST_LW, INST_SW})     cur <= S_MEM;
          else                                             cur <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            cur      <= (dec_inst == INST_LW) ? S_WB : S_FETCH;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            cur      <= S_HALT;
            bus_err  <= 1'b1;
            halt_sig <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          cur      <= S_FETCH;
          wait_cnt <= '0;
        end
        S_HALT: begin
          halt_sig <= 1'b1;
          wait_cnt <= '0;
        end
        default: begin
          cur      <= S_RST;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    alu_sel            = ALU_SEL_ADD;
    gpr_write_addr_sel = GPR_WRITE_ADDR_RT;
    gpr_write_data_sel = GPR_WRITE_ALU;
    alu_src_ctl        = ALU_SRC_EXT;
    ext_ctl            = EXT_SEL_SIGN;
    if (cur inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      case (dec_inst)
        INST_ADDU: begin
          gpr_write_addr_sel = GPR_WRITE_ADDR_RD;
          alu_src_ctl        = ALU_SRC_GPR;
        end
        INST_SUBU: begin
          alu_sel            = ALU_SEL_SUB;
          gpr_write_addr_sel = GPR_WRITE_ADDR_RD;
          alu_src_ctl        = ALU_SRC_GPR;
        end
        INST_SLT: begin
          alu_sel            = ALU_SEL_SLT;
          gpr_write_addr_sel = GPR_WRITE_ADDR_RD;
          alu_src_ctl        = ALU_SRC_GPR;
        end
        INST_ORI: begin
          alu_sel = ALU_SEL_OR;
          ext_ctl = EXT_SEL_ZERO;
        end
        INST_LUI: ext_ctl = EXT_SEL_LUI;
        INST_LW:  gpr_write_data_sel = GPR_WRITE_MEM;
        INST_BEQ: begin
          alu_sel     = ALU_SEL_SUB;
          alu_src_ctl = ALU_SRC_GPR;
        end
        INST_JAL: begin
          gpr_write_addr_sel = GPR_WRITE_ADDR_RA;
          gpr_write_data_sel = GPR_WRITE_PC;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    reg_write_en = 1'b0;
    reg_of_en    = 1'b0;
    mem_write_en = 1'b0;
    npc_sel      = IFU_SEL_NORM;
    case (cur)
      S_FETCH: begin
        imem_req    = 1'b1;
        ir_write_en = imem_ready;
      end
      S_DECODE: pc_write_en = !known;
      S_EXEC: begin
        case (dec_inst)
          INST_BEQ: begin
            pc_write_en = 1'b1;
            npc_sel     = zero ? IFU_SEL_RELATIVE : IFU_SEL_NORM;
          end
          INST_J: begin
            pc_write_en = 1'b1;
            npc_sel     = IFU_SEL_IRRELATIVE;
          end
          INST_JR: begin
            pc_write_en = 1'b1;
            npc_sel     = IFU_SEL_REGISTER;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req     = 1'b1;
        mem_write_en = (dec_inst == INST_SW);
        pc_write_en  = dmem_ready && (dec_inst != INST_LW);
      end
      S_WB: begin
        reg_write_en = 1'b1;
        reg_of_en    = (dec_inst == INST_ADDI);
        pc_write_en  = 1'b1;
        npc_sel      = (dec_inst == INST_JAL) ? IFU_SEL_IRRELATIVE : IFU_SEL_NORM;
      end
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  // Unknown-instruction skips advance the PC but do not count as retired.
  logic skip;
  assign skip = (cur == S_DECODE) && !known;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt    <= 32'd0;
      inst_retired <= 32'd0;
    end else begin
      if (cur != S_RST && cur != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_write_en && !skip)          inst_retired <= inst_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
// Exercises PERF_CNT_EN counters when that macro is defined.
module tb_multicycle_controller;

  localparam logic [5:0] ADDU = 6'd1, SUBU = 6'd2, SLT = 6'd3, ORI = 6'd4, LUI = 6'd5,
                         LW = 6'd6, SW = 6'd7, BEQ = 6'd8, J = 6'd9, JAL = 6'd10,
                         JR = 6'd11, ADDI = 6'd12, HLT = 6'd13;
  localparam logic [2:0] RST = 3'd0, FE = 3'd1, DE = 3'd2, EX = 3'd3, ME = 3'd4, WB = 3'd5, HA = 3'd6;
  localparam logic [1:0] NORM = 2'd0, REL = 2'd1, IRREL = 2'd2, REG = 2'd3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] dec_inst = '0;
  logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, ir_write_en, pc_write_en, reg_write_en, reg_of_en, mem_write_en;
  logic [1:0] alu_sel, gpr_write_addr_sel, gpr_write_data_sel, ext_ctl, npc_sel;
  logic alu_src_ctl, halt_sig, bus_err;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, inst_retired;
`endif

  int n_cmp = 0, n_err = 0;

  multicycle_controller #(.INST_W(6), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .dec_inst(dec_inst), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write_en(ir_write_en),
    .pc_write_en(pc_write_en), .reg_write_en(reg_write_en), .reg_of_en(reg_of_en),
    .mem_write_en(mem_write_en), .alu_sel(alu_sel), .gpr_write_addr_sel(gpr_write_addr_sel),
    .gpr_write_data_sel(gpr_write_data_sel), .alu_src_ctl(alu_src_ctl), .ext_ctl(ext_ctl),
    .npc_sel(npc_sel), .halt_sig(halt_sig), .bus_err(bus_err), .state(state)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .inst_retired(inst_retired)
`endif
  );

  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {state, imem_req, dmem_req, ir_write_en, pc_write_en, reg_write_en, reg_of_en,
                mem_write_en, alu_sel, gpr_write_addr_sel, gpr_write_data_sel, alu_src_ctl,
                ext_ctl, npc_sel, halt_sig, bus_err};

  // Select table: {alu, waddr, wdata, src, ext}
  function automatic logic [8:0] sel_of(input logic [5:0] i);
    case (i)
      ADDU:    return {2'd0, 2'd1, 2'd0, 1'b1, 2'd0};
      SUBU:    return {2'd1, 2'd1, 2'd0, 1'b1, 2'd0};
      SLT:     return {2'd3, 2'd1, 2'd0, 1'b1, 2'd0};
      ORI:     return {2'd2, 2'd0, 2'd0, 1'b0, 2'd1};
      LUI:     return {2'd0, 2'd0, 2'd0, 1'b0, 2'd2};
      LW:      return {2'd0, 2'd0, 2'd1, 1'b0, 2'd0};
      BEQ:     return {2'd1, 2'd0, 2'd0, 1'b1, 2'd0};
      JAL:     return {2'd0, 2'd2, 2'd2, 1'b0, 2'd0};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [22:0] ev(input logic [2:0] st, input logic [6:0] en,
                                     input logic [8:0] sel, input logic [1:0] npc,
                                     input logic h, input logic b);
    return {st, en, sel, npc, h, b};
  endfunction

  task automatic chk(input string tag, input logic [22:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] exp);
    n_cmp++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [5:0] di, input logic ir, input logic dr,
                     input logic z, input logic [22:0] exp);
    @(negedge clk);
    dec_inst = di; imem_ready = ir; dmem_ready = dr; zero = z;
    #1 chk(tag, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("reset_low", 23'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1;
    #1 chk("reset_release", 23'd0);
  endtask

  // Walks one instruction through the phase sequence the rules call for.
  task automatic run_inst(input logic [5:0] i, input logic z, input int istall, input int dstall);
    logic [8:0] s;
    logic k;
    s = sel_of(i);
    k = (i >= 6'd1 && i <= 6'd13);
    for (int n = 0; n < istall; n++)
      cyc("fetch_wait", 6'($urandom), 1'b0, 1'($urandom), 1'($urandom), ev(FE, 7'b1000000, 9'd0, NORM, 0, 0));
    cyc("fetch", 6'($urandom), 1'b1, 1'($urandom), 1'($urandom), ev(FE, 7'b1010000, 9'd0, NORM, 0, 0));
    if (!k) begin
      cyc("decode_skip", i, 1'($urandom), 1'($urandom), z, ev(DE, 7'b0001000, 9'd0, NORM, 0, 0));
      return;
    end
    cyc("decode", i, 1'($urandom), 1'($urandom), z, ev(DE, 7'b0, s, NORM, 0, 0));
    if (i == HLT) return;
    case (i)
      BEQ: begin cyc("exec_beq", i, 1'($urandom), 1'($urandom), z, ev(EX, 7'b0001000, s, z ? REL : NORM, 0, 0)); return; end
      J:   begin cyc("exec_j",   i, 1'($urandom), 1'($urandom), z, ev(EX, 7'b0001000, s, IRREL, 0, 0)); return; end
      JR:  begin cyc("exec_jr",  i, 1'($urandom), 1'($urandom), z, ev(EX, 7'b0001000, s, REG, 0, 0)); return; end
      default: cyc("exec", i, 1'($urandom), 1'($urandom), z, ev(EX, 7'b0, s, NORM, 0, 0));
    endcase
    if (i == LW || i == SW) begin
      for (int n = 0; n < dstall; n++)
        cyc("mem_wait", i, 1'($urandom), 1'b0, z, ev(ME, {6'b010000, i == SW}, s, NORM, 0, 0));
      if (i == SW) begin
        cyc("mem_sw", i, 1'($urandom), 1'b1, z, ev(ME, 7'b0101001, s, NORM, 0, 0));
        return;
      end
      cyc("mem_lw", i, 1'($urandom), 1'b1, z, ev(ME, 7'b0100000, s, NORM, 0, 0));
    end
    cyc("wb", i, 1'($urandom), 1'($urandom), z,
        ev(WB, {4'b0001, 1'b1, i == ADDI, 1'b0}, s, (i == JAL) ? IRREL : NORM, 0, 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [5:0] ri;
    #1 chk("reset_init", 23'd0);
    do_reset();
    run_inst(ADDU, 1'b0, 0, 0);
    run_inst(BEQ, 1'b1, 0, 0);
    run_inst(BEQ, 1'b0, 0, 0);
    run_inst(LW, 1'b0, 0, 3);
    run_inst(SW, 1'b0, 0, 3);
    run_inst(6'd63, 1'b0, 0, 0);
    run_inst(JAL, 1'b0, 3, 0);

    for (int n = 0; n < 60; n++) begin
      ri = 6'($urandom_range(0, 12));
      if (ri == 6'd0) ri = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(14, 63));
      run_inst(ri, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef PERF_CNT_EN
    do_reset();
    for (int n = 0; n < 10; n++) run_inst(ADDU, 1'b0, 0, 0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk32("cycle_cnt", cycle_cnt, 32'd40);
    chk32("inst_retired", inst_retired, 32'd10);
`endif

    do_reset();
    for (int n = 0; n < 4; n++)
      cyc("timeout_wait", 6'($urandom), 1'b0, 1'b1, 1'b0, ev(FE, 7'b1000000, 9'd0, NORM, 0, 0));
    for (int n = 0; n < 3; n++)
      cyc("timeout_halt", 6'($urandom), 1'b1, 1'b1, 1'b0, ev(HA, 7'b0, 9'd0, NORM, 1, 1));
    do_reset();

    run_inst(HLT, 1'b0, 0, 0);
    for (int n = 0; n < 20; n++)
      cyc("halt_hold", 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ev(HA, 7'b0, 9'd0, NORM, 1, 0));

    do_reset();
    cyc("sw_fetch", ADDU, 1'b1, 1'b0, 1'b0, ev(FE, 7'b1010000, 9'd0, NORM, 0, 0));
    cyc("sw_decode", SW, 1'b0, 1'b0, 1'b0, ev(DE, 7'b0, 9'd0, NORM, 0, 0));
    cyc("sw_exec", SW, 1'b0, 1'b0, 1'b0, ev(EX, 7'b0, 9'd0, NORM, 0, 0));
    cyc("sw_mem_stall", SW, 1'b0, 1'b0, 1'b0, ev(ME, 7'b0100001, 9'd0, NORM, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_mem", 23'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_inst(ORI, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
